ripple_count_sampler: RTL
=========================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit ripple counter output.
- Ripple outputs settle bit-by-bit and are not timed to clk, so this block resynchronises the 4-bit value and filters out transient codes.
- Extends the count to a wider value by detecting 4-bit wrap-arounds.
- Delivers snapshots of the extended count to a consumer over a valid/ready handshake.

Parameters:
- STABLE_CYC, 2, consecutive identical synchronised samples required before a value is accepted (range 1..15).
- EXT_W, 8, width of the wrap-extension counter (upper bits of the extended count).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  reset, synchronous and active-high (asserted = 1, sampled on the clk rising edge).
- cnt_in  input  4  raw count from the ripple counter; asynchronous to clk.
- sample_req  input  1  single-cycle request to capture a snapshot.
- out_ready  input  1  consumer accepts the snapshot when high together with out_valid.
- out_valid  output  1  snapshot held on out_count.
- out_count  output  4+EXT_W  snapshot, {ext, accepted value}.
- wrap_pulse  output  1  one-cycle pulse on each accepted wrap.
- ext_ovf  output  1  sticky flag: the extension counter rolled over.
- req_miss  output  1  sticky flag: a sample_req was dropped.

Behaviour:
- Reset (rstn=1 at a clk edge) clears:
  - both sync stages, the stability counter, the accepted value, ext and the FSM (to IDLE);
  - all outputs: out_valid=0, out_count=0, wrap_pulse=0, ext_ovf=0, req_miss=0.
- Reset mid-handshake drops the pending snapshot with no further response.
- Synchroniser: two flops, s1<=cnt_in, s2<=s1. No logic between the two stages.
- Stability filter:
  - cand holds the last s2 value; stab_cnt is 4 bits.
  - If s2==cand, stab_cnt increments, saturating at STABLE_CYC. Otherwise cand<=s2 and stab_cnt<=1.
  - The cycle stab_cnt reaches STABLE_CYC with cand!=acc: acc<=cand ("accept event").
  - Latency: cnt_in change to acc update is 2+STABLE_CYC cycles.
- Wrap detection:
  - On an accept event with cand<acc (unsigned): ext<=ext+1 and wrap_pulse=1 in the following cycle.
  - If ext was all-ones, ext wraps to 0 and ext_ovf sets; it stays set until reset.
  - Non-decreasing accepts do not change ext.
  - The block assumes at most 15 counts between accepts, i.e. the ripple clock is slow relative to clk·STABLE_CYC. Faster input is out of spec.
- Snapshot FSM, two states:
  - IDLE: on sample_req=1, out_count<={ext_next, acc_next}, where the _next values include any accept/wrap happening in the same cycle. Then out_valid<=1 and go to HOLD.
  - HOLD: out_count is frozen.
    - out_valid&&out_ready: out_valid<=0 and go to IDLE the next cycle.
    - sample_req in HOLD (including the handshake cycle): the request is dropped and req_miss sets (sticky).
- No back-to-back capture: the earliest new capture is in the cycle after out_valid falls.
- out_ready while out_valid=0 is ignored.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset check: drive rstn=1 for 3 cycles with cnt_in=4'hF, then release → all outputs 0; acc=F is accepted 2+STABLE_CYC=4 cycles later; wrap_pulse stays 0 (F>0).
- Glitch rejection: hold cnt_in=4'h7 until accepted, then pulse cnt_in=4'h0 for 1 cycle, back to 7 → acc stays 7, no wrap_pulse, ext=0.
- Wrap extension: step cnt_in 0→1→…→F→0→1, each value held 6 cycles → exactly one wrap_pulse at the F→0 accept. Then sample_req gives out_count=12'h011 (EXT_W=8) with out_valid=1.
- Handshake hold: capture, keep out_ready=0 for 10 cycles while cnt_in advances → out_count unchanged. Set out_ready=1 → out_valid drops next cycle. A new sample_req then captures the updated value.
- Dropped request: assert sample_req while out_valid=1 → req_miss=1 and stays set; out_count unchanged.
- Extension overflow: EXT_W=2, drive 4 full wraps → ext sequence 1,2,3,0; ext_ovf=1 after the 4th wrap. A mid-run rstn=1 then clears ext_ovf, ext, out_valid.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// ripple_count_sampler
//
// Consumes the 4-bit output of a free-running ripple counter that is not
// timed to clk. The raw value is resynchronised, filtered so that codes seen
// while the ripple bits are still settling are never taken, and then extended
// to a wider count. The extension counts 4-bit wrap-arounds. On request, a
// snapshot of the extended count is offered to a consumer over a valid/ready
// handshake.
//
// Parameters
//   STABLE_CYC : consecutive identical synchronised samples needed to accept
//                a value (1..15)
//   EXT_W      : width of the wrap-extension counter (upper bits of out_count)
//
// Ports
//   clk        : system clock, rising edge
//   rstn       : synchronous reset, active HIGH despite the name
//   cnt_in     : raw ripple count, asynchronous to clk
//   sample_req : single-cycle snapshot request
//   out_ready  : consumer accepts the snapshot when high with out_valid
//   out_valid  : a snapshot is being held on out_count
//   out_count  : snapshot {ext, accepted value}
//   wrap_pulse : one-cycle pulse for each accepted wrap
//   ext_ovf    : sticky, the extension counter rolled over
//   req_miss   : sticky, a sample_req arrived while a snapshot was held
// ---------------------------------------------------------------------------
module ripple_count_sampler #(
  parameter int STABLE_CYC = 2,
  parameter int EXT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       cnt_in,
  input  logic             sample_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [EXT_W+3:0] out_count,
  output logic             wrap_pulse,
  output logic             ext_ovf,
  output logic             req_miss
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYC);

  typedef enum logic {IDLE, HOLD} state_t;

  // synchroniser
  logic [3:0]       r_s1, r_s2;
  // stability filter / accepted value
  logic [3:0]       r_cand, r_stab_cnt, r_acc;
  // wrap extension
  logic [EXT_W-1:0] r_ext;
  // snapshot path
  state_t           r_state, w_state_nxt;
  logic             r_out_valid, r_wrap_pulse, r_ext_ovf, r_req_miss;
  logic [EXT_W+3:0] r_out_count;

  logic             w_same, w_reach, w_accept, w_wrap, w_ext_carry;
  logic [3:0]       w_stab_nxt, w_acc_nxt;
  logic [EXT_W-1:0] w_ext_nxt;
  logic             w_capture, w_release, w_miss;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. Nothing may sit between the stages.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= cnt_in;
      r_s2 <= r_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Stability filter and wrap detection.
  // The candidate always follows s2: when s2 matches it nothing changes, and
  // when it differs the candidate is reloaded with s2. The acceptance test
  // therefore looks at s2 directly, which also makes STABLE_CYC=1 work (the
  // value is taken in the same cycle it first becomes the candidate).
  // "Reach" fires only on the cycle the count arrives at STABLE_CYC, not
  // while it sits saturated there.
  // -------------------------------------------------------------------------
  always_comb begin
    w_same     = (r_s2 == r_cand);
    w_stab_nxt = 4'd1;
    if (w_same)
      w_stab_nxt = (r_stab_cnt == STAB_MAX) ? STAB_MAX : r_stab_cnt + 4'd1;
    w_reach     = (w_stab_nxt == STAB_MAX) && (!w_same || (r_stab_cnt != STAB_MAX));
    w_accept    = w_reach && (r_s2 != r_acc);
    // A smaller accepted value means the ripple counter passed through 0.
    w_wrap      = w_accept && (r_s2 < r_acc);
    w_acc_nxt   = w_accept ? r_s2 : r_acc;
    w_ext_nxt   = w_wrap ? r_ext + EXT_W'(1) : r_ext;
    w_ext_carry = w_wrap && (&r_ext);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_cand       <= '0;
      r_stab_cnt   <= '0;
      r_acc        <= '0;
      r_ext        <= '0;
      r_wrap_pulse <= 1'b0;
      r_ext_ovf    <= 1'b0;
    end else begin
      r_cand       <= r_s2;
      r_stab_cnt   <= w_stab_nxt;
      r_acc        <= w_acc_nxt;
      r_ext        <= w_ext_nxt;
      r_wrap_pulse <= w_wrap;
      if (w_ext_carry)
        r_ext_ovf <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Snapshot FSM. IDLE captures on a request; HOLD freezes the snapshot
  // until the consumer takes it. Requests seen in HOLD (including the
  // handshake cycle itself) are dropped and flagged.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_req) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (sample_req)
          w_miss = 1'b1;
        if (r_out_valid && out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture uses the _nxt values so an accept or wrap landing in the same
  // cycle as the request is already reflected in the snapshot.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_req_miss  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_count <= {w_ext_nxt, w_acc_nxt};
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
      if (w_miss)
        r_req_miss <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_count  = r_out_count;
  assign wrap_pulse = r_wrap_pulse;
  assign ext_ovf    = r_ext_ovf;
  assign req_miss   = r_req_miss;

endmodule
